div: RTL and testbench

Multi-cycle 32-bit integer divider serving the EX stage for `div`/`divu`. EX drives operands, a signed flag and a start request; this block runs a restoring shift-subtract algorithm (one quotient bit per cycle) and returns `{remainder, quotient}` with a ready flag. The 64-bit result maps directly onto HI/LO: HI holds the remainder, LO holds the quotient. EX stalls the pipeline until ready is seen.

---
 rtl/div_if.sv | 20 ++
 rtl/div.sv | 125 ++++++++++++
 tb/tb_div.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle between the EX stage (master) and the divider (slave).
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Restoring 32-bit div/divu, one quotient bit per cycle; result {rem, quo} after 33 edges (1 for /0).
// No backpressure: EX holds start until ready, and dropping start or annul abandons the division.
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        op1_neg, op2_neg, abort;
  logic [31:0] abs1, abs2, q_fix, r_fix;
  logic [32:0] trial;

  always_comb begin
    op1_neg = bus.signed_div_i & bus.opdata1_i[31];
    op2_neg = bus.signed_div_i & bus.opdata2_i[31];
    abs1    = op1_neg ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    abs2    = op2_neg ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    abort   = bus.annul_i | ~bus.start_i;
    // Bit 32 of the 33-bit difference is set exactly when the shifted remainder is below the divisor.
    trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    q_fix   = qneg_q ? (~quo_q + 32'd1) : quo_q;
    r_fix   = rneg_q ? (~rem_q + 32'd1) : rem_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            quo_d   = abs1;
            dvs_d   = abs2;
            qneg_d  = op1_neg ^ op2_neg;
            rneg_d  = op1_neg;
          end
        end
      end
      BYZERO: begin
        if (abort) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (abort) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
          rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
          quo_d = {quo_q[30:0], ~trial[32]};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end
      end
      END: begin
        if (abort) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands against an arithmetic model.
module tb_div;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  div_if bus ();

  div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: divide magnitudes with wide arithmetic, then apply the sign rules.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, q, r;
    bit     na, nb;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    na = sgn && a[31];
    nb = sgn && b[31];
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (na) ua = 64'h1_0000_0000 - ua;
    if (nb) ub = 64'h1_0000_0000 - ub;
    q = ua / ub;
    r = ua % ub;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Starts a division and waits (bounded) for ready; lat = edges after E0, -1 on timeout.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                         output logic [63:0] res, output int lat, output bit busy_nz);
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    lat     = -1;
    busy_nz = 1'b0;
    res     = 64'd0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        lat = n;
        res = bus.result_o;
        break;
      end
      if (bus.result_o !== 64'd0) busy_nz = 1'b1;
      if (scramble) begin
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL reset_outputs: ready=%b result=%h, required ready=0 result=0", bus.ready_o, bus.result_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL idle_after_reset: ready=%b result=%h, required ready=0 result=0", bus.ready_o, bus.result_o);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    logic [63:0] res;
    int lat;
    bit bnz;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, res, lat, bnz);
    n_total++;
    if (res !== 64'h00000002_0000000E) $display("FAIL u100_7: got %h, required %h", res, 64'h00000002_0000000E);
    else n_pass++;
    n_total++;
    if (lat !== 33) $display("FAIL u100_7_latency: got %0d edges, required 33", lat);
    else n_pass++;
    n_total++;
    if (bnz) $display("FAIL busy_result_zero: result nonzero while ready low, required 0");
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E)
      $display("FAIL end_hold: ready=%b result=%h, required ready=1 result=%h", bus.ready_o, bus.result_o, 64'h00000002_0000000E);
    else n_pass++;
    drop_start();
    n_total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL end_release: ready=%b result=%h, required ready=0 result=0", bus.ready_o, bus.result_o);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [63:0] res;
    int lat;
    bit bnz;
    bit          sg [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] da [5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] db [5] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
    logic [63:0] ex [5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000,
                            64'h80000000_00000000, 64'h00000000_FFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      run_div(sg[i], da[i], db[i], 1'b0, res, lat, bnz);
      n_total++;
      if (res !== ex[i] || lat !== 33)
        $display("FAIL directed_%0d: got %h after %0d edges, required %h after 33", i, res, lat, ex[i]);
      else n_pass++;
      drop_start();
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int lat;
    bit bnz;
    for (int m = 0; m < 2; m++) begin
      run_div(m[0], $urandom, 32'd0, 1'b0, res, lat, bnz);
      n_total++;
      if (res !== 64'd0 || lat !== 1)
        $display("FAIL div_zero_mode%0d: got %h after %0d edges, required 0 after 1", m, res, lat);
      else n_pass++;
      drop_start();
    end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int lat, seen;
    bit bnz;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL annul_no_ready: ready high on %0d cycles, required 0", seen);
    else n_pass++;
    run_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat, bnz);
    n_total++;
    if (res !== 64'h00000000_00000003 || lat !== 33)
      $display("FAIL after_annul_9_3: got %h after %0d edges, required %h after 33", res, lat, 64'h3);
    else n_pass++;
    drop_start();
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat;
    bit bnz;
    @(negedge clk);
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd67;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL reset_mid_on: ready=%b result=%h, required ready=0 result=0", bus.ready_o, bus.result_o);
    else n_pass++;
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b0, 32'd50, 32'd8, 1'b1, res, lat, bnz);
    n_total++;
    if (res !== 64'h00000002_00000006 || lat !== 33)
      $display("FAIL restart_50_8: got %h after %0d edges, required %h after 33", res, lat, 64'h00000002_00000006);
    else n_pass++;
    // Reset while holding a finished result must clear the outputs without waiting for an edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL reset_in_end: ready=%b result=%h, required ready=0 result=0", bus.ready_o, bus.result_o);
    else n_pass++;
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [63:0] res, exp_res;
    logic [31:0] a, b;
    bit sgn, bnz;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      sgn = $urandom_range(0, 1);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(0, 31);
      exp_res = ref_div(sgn, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      run_div(sgn, a, b, 1'b0, res, lat, bnz);
      n_total++;
      if (res !== exp_res || lat !== exp_lat || bnz)
        $display("FAIL random_%0d: s=%0d %h/%h got %h after %0d edges, required %h after %0d", i, sgn, a, b, res, lat, exp_res, exp_lat);
      else n_pass++;
      drop_start();
    end
  endtask

  initial begin
    n_pass           = 0;
    n_total          = 0;
    clk              = 1'b0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    test_reset();
    test_unsigned();
    test_directed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
